// File: rtl/ap_txn_profiler.sv
// ---------------------------------------------------------------------------
// ap_txn_profiler
//
// Watches the ap_start / ap_ready / ap_done handshake of an HLS-style kernel
// and measures three numbers for every transaction:
//   latency    - cycles from the start cycle up to and including the done cycle
//   interval   - cycles from the start cycle up to and including the first
//                ap_ready cycle (equal to latency when ap_ready never arrives)
//   iter_count - number of pipelined-loop iteration starts seen in between
// Each finished transaction is tagged with a running transaction id and
// queued in a small first-word-fall-through record FIFO. A record that finds
// the FIFO full (with no simultaneous pop) is thrown away and counted.
//
// Ports
//   clock        rising-edge clock for all state
//   reset        synchronous, active-high reset
//   ap_start     observed kernel ap_start
//   ap_ready     observed kernel ap_ready
//   ap_done      observed kernel ap_done
//   iter_enable  one-cycle pulse per loop iteration start
//   rec_valid    a record is available at the FIFO head
//   rec_ready    downstream accepts the head record
//   rec_data     {txn_id, latency, interval, iter_count}, txn_id in the MSBs
//   busy         a transaction is in progress
//   drop_cnt     saturating count of records lost to a full FIFO
// ---------------------------------------------------------------------------
module ap_txn_profiler #(
    parameter int CNT_W = 32,
    parameter int ID_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ap_start,
    input  logic                      ap_ready,
    input  logic                      ap_done,
    input  logic                      iter_enable,
    output logic                      rec_valid,
    input  logic                      rec_ready,
    output logic [ID_W+3*CNT_W-1:0]   rec_data,
    output logic                      busy,
    output logic [15:0]               drop_cnt
);

    localparam int REC_W = ID_W + 3 * CNT_W;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]  ID_ONE  = {{(ID_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [15:0]      DROP_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             stateNext;

    logic [CNT_W-1:0]   latency;
    logic [CNT_W-1:0]   interval;
    logic [CNT_W-1:0]   iterCount;
    logic               readySeen;

    logic [CNT_W-1:0]   latencyNext;
    logic [CNT_W-1:0]   intervalNext;
    logic [CNT_W-1:0]   iterCountNext;
    logic               readySeenNext;
    logic               txnDone;

    logic [ID_W-1:0]    txnId;
    logic [REC_W-1:0]   newRecord;

    logic [REC_W-1:0]   mem [DEPTH];
    logic [AW:0]        wrPtr;
    logic [AW:0]        rdPtr;
    logic               fifoEmpty;
    logic               fifoFull;
    logic               pop;
    logic               pushAccept;
    logic               pushDrop;

    // Counters saturate instead of wrapping so that a pathologically long
    // transaction shows up as "at least this many" rather than a small number.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_ONE;
    endfunction

    // State register for the IDLE/RUN transaction tracker. Reset wins over
    // every handshake input in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and next-counter logic. In IDLE a start loads fresh counter
    // values that already include the start cycle; a done in that same cycle
    // completes a one-cycle transaction without ever entering RUN. In RUN the
    // counters advance every cycle, interval freezing once ap_ready has been
    // counted. The counter values handed to the record are the *next* values,
    // so the done cycle itself is always included.
    always_comb begin
        stateNext     = state;
        latencyNext   = latency;
        intervalNext  = interval;
        iterCountNext = iterCount;
        readySeenNext = readySeen;
        txnDone       = 1'b0;

        case (state)
            IDLE: begin
                if (ap_start) begin
                    latencyNext   = CNT_ONE;
                    intervalNext  = CNT_ONE;
                    iterCountNext = {{(CNT_W-1){1'b0}}, iter_enable};
                    readySeenNext = ap_ready;
                    if (ap_done) begin
                        txnDone = 1'b1;
                    end else begin
                        stateNext = RUN;
                    end
                end
            end

            RUN: begin
                latencyNext = satInc(latency);
                if (!readySeen) begin
                    intervalNext = satInc(interval);
                end
                if (ap_ready) begin
                    readySeenNext = 1'b1;
                end
                if (iter_enable) begin
                    iterCountNext = satInc(iterCount);
                end
                if (ap_done) begin
                    txnDone   = 1'b1;
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign newRecord = {txnId, latencyNext, intervalNext, iterCountNext};

    // Measurement counters. They simply follow the next-value logic; their
    // contents in IDLE are don't-care because a new start reloads them.
    always_ff @(posedge clock) begin
        if (reset) begin
            latency   <= '0;
            interval  <= '0;
            iterCount <= '0;
            readySeen <= 1'b0;
        end else begin
            latency   <= latencyNext;
            interval  <= intervalNext;
            iterCount <= iterCountNext;
            readySeen <= readySeenNext;
        end
    end

    // Transaction id advances on every completed transaction, whether its
    // record made it into the FIFO or was dropped, so gaps in the id sequence
    // seen downstream reveal exactly which transactions were lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            txnId <= '0;
        end else if (txnDone) begin
            txnId <= txnId + ID_ONE;
        end
    end

    // FIFO bookkeeping. Pointers carry one extra wrap bit so that full and
    // empty can be told apart without a separate occupancy counter. A push
    // into a full FIFO is still accepted when the head is popped in the same
    // cycle, because the slot being vacated is the one the write lands in.
    assign fifoEmpty  = (wrPtr == rdPtr);
    assign fifoFull   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign pop        = rec_valid && rec_ready;
    assign pushAccept = txnDone && (!fifoFull || pop);
    assign pushDrop   = txnDone && fifoFull && !pop;

    // Read and write pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushAccept) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
        end
    end

    // Record storage. No reset is needed because a slot is only ever read
    // after it has been written, and the output is forced to zero when empty.
    always_ff @(posedge clock) begin
        if (pushAccept) begin
            mem[wrPtr[AW-1:0]] <= newRecord;
        end
    end

    // Saturating drop counter for records that had nowhere to go.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (pushDrop && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Outputs. The head record is presented straight from storage, so it
    // cannot change while it waits for rec_ready; a push into an empty FIFO
    // only becomes visible once the write pointer has moved.
    assign rec_valid = !fifoEmpty;
    assign rec_data  = fifoEmpty ? '0 : mem[rdPtr[AW-1:0]];
    assign busy      = (state == RUN);

endmodule
